// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment driver: segment polarity and the
// active-low hex glyphs (bit 0 = a ... bit 6 = g).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;
  localparam seg_t SEG_BLANK = {7{SEG_OFF}};

  localparam seg_t GLYPH_0 = 7'b1000000;
  localparam seg_t GLYPH_1 = 7'b1111001;
  localparam seg_t GLYPH_2 = 7'b0100100;
  localparam seg_t GLYPH_3 = 7'b0110000;
  localparam seg_t GLYPH_4 = 7'b0011001;
  localparam seg_t GLYPH_5 = 7'b0010010;
  localparam seg_t GLYPH_6 = 7'b0000010;
  localparam seg_t GLYPH_7 = 7'b1111000;
  localparam seg_t GLYPH_8 = 7'b0000000;
  localparam seg_t GLYPH_9 = 7'b0010000;
  localparam seg_t GLYPH_A = 7'b0001000;
  localparam seg_t GLYPH_B = 7'b0000011;
  localparam seg_t GLYPH_C = 7'b1000110;
  localparam seg_t GLYPH_D = 7'b0100001;
  localparam seg_t GLYPH_E = 7'b0000110;
  localparam seg_t GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-side and pin-side signals of the scan driver, grouped as one bundle.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lzs_en;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              seg7;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value, load, digit_en, blink_mask, lzs_en, dp_in,
    input  seg7, dp, an, frame_done
  );

  modport slave (
    input  value, load, digit_en, blink_mask, lzs_en, dp_in,
    output seg7, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_hex_lut.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       glyph_o
);

  always_comb begin
    glyph_o = SEG_BLANK;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with double-buffered value,
// blinking, leading-zero suppression and one dead cycle per digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic [VW-1:0]         shad_q, shad_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  blink_on_q, blink_on_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  logic          tick, wrap, blank, lz;
  logic [VW-1:0] upper;
  logic [3:0]    nib;
  seg_t          glyph;

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));

  // Nibbles from the scanned digit upward; all-zero means a leading zero.
  assign upper = shad_q >> {idx_q, 2'b00};
  assign nib   = upper[3:0];
  assign lz    = bus.lzs_en && (idx_q != '0) && (upper == '0);
  assign blank = !bus.digit_en[idx_q]
               || (bus.blink_mask[idx_q] && !blink_on_q)
               || lz;

  seg7_hex_lut u_lut (
    .nibble_i (nib),
    .glyph_o  (glyph)
  );

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    // A load coinciding with the wrap lands in shadow via pend_d.
    pend_d     = bus.load ? bus.value : pend_q;
    shad_d     = wrap ? pend_d : shad_q;

    fcnt_d     = fcnt_q;
    blink_on_d = blink_on_q;
    if (wrap) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d     = '0;
        blink_on_d = !blink_on_q;
      end else begin
        fcnt_d     = fcnt_q + 1'b1;
      end
    end

    seg_d = SEG_BLANK;
    dp_d  = SEG_OFF;
    an_d  = '1;
    if (!tick && !blank) begin
      seg_d = glyph;
      dp_d  = bus.dp_in[idx_q] ? SEG_ON : SEG_OFF;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) == idx_q) an_d[i] = 1'b0;
      end
    end
    fd_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      shad_q     <= '0;
      fcnt_q     <= '0;
      blink_on_q <= 1'b1;
      seg_q      <= SEG_BLANK;
      dp_q       <= SEG_OFF;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      shad_q     <= shad_d;
      fcnt_q     <= fcnt_d;
      blink_on_q <= blink_on_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.seg7       = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-level reference model plus directed
// table vectors and multi-cycle sequences (coherence, blink, async reset).
module tb_seg7_scan_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned R  = 4;
  localparam int unsigned BF = 2;
  localparam int unsigned RN = N * R;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // k = rising edges since reset release; loads are tagged with their edge.
  int unsigned k = 0;
  int unsigned ld_edge [$];
  logic [15:0] ld_val  [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      ld_edge.delete();
      ld_val.delete();
    end else begin
      if (bus.load === 1'b1) begin
        ld_edge.push_back(k + 1);
        ld_val.push_back(bus.value);
      end
      k <= k + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
  endtask

  // Output state after edge kk, from slot arithmetic and the load history.
  task automatic model(input int unsigned kk, output logic [6:0] s, output logic d,
                       output logic [3:0] a, output logic fd, output logic dead);
    int unsigned c, pos, idx, f;
    logic [15:0] sh, upper;
    logic vis, blank;
    s = 7'h7F; d = 1'b1; a = 4'hF; fd = 1'b0; dead = 1'b0;
    if (kk != 0) begin
      c    = kk - 1;
      pos  = c % R;
      idx  = (c / R) % N;
      f    = c / RN;
      fd   = ((c % RN) == RN - 1);
      dead = (pos == R - 1);
      sh   = '0;
      foreach (ld_edge[j]) if (ld_edge[j] <= f * RN) sh = ld_val[j];
      vis   = ((f / BF) % 2 == 0);
      upper = sh >> (4 * idx);
      blank = !bus.digit_en[idx] || (bus.blink_mask[idx] && !vis)
            || (bus.lzs_en && idx > 0 && upper == 16'h0);
      if (!dead && !blank) begin
        s = gl[upper[3:0]];
        d = ~bus.dp_in[idx];
        a = ~(4'b0001 << idx);
      end
    end
  endtask

  always @(posedge clk) begin
    logic [6:0] s;
    logic d, fd, dead;
    logic [3:0] a;
    #1;
    model(k, s, d, a, fd, dead);
    if (dead) check("scan_dead", {bus.frame_done, bus.an}, {fd, a});
    else      check("scan", {bus.frame_done, bus.dp, bus.an, bus.seg7}, {fd, d, a, s});
  end

  task automatic goto(input int unsigned kt);
    int unsigned guard = 0;
    while (k != kt && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (k != kt) begin
      n_total++;
      $display("FAIL goto: k=%0d target=%0d", k, kt);
    end
  endtask

  task automatic do_load(input logic [15:0] v, output int unsigned e);
    bus.value = v;
    bus.load  = 1'b1;
    e = k + 1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0]     val;
    logic            lzs;
    logic [3:0]      en;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t tv [8];

  initial begin
    int unsigned e, f;
    logic [3:0] exp_an;

    tv[0] = '{16'h1A3F, 1'b0, 4'hF, 4'hF, {7'h79, 7'h08, 7'h30, 7'h0E}};
    tv[1] = '{16'h0050, 1'b1, 4'hF, 4'h3, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    tv[2] = '{16'h0000, 1'b1, 4'hF, 4'h1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    tv[3] = '{16'h8000, 1'b1, 4'hF, 4'hF, {7'h00, 7'h40, 7'h40, 7'h40}};
    tv[4] = '{16'h2109, 1'b0, 4'hA, 4'hA, {7'h24, 7'h7F, 7'h40, 7'h7F}};
    tv[5] = '{16'hE4B7, 1'b1, 4'hF, 4'hF, {7'h06, 7'h19, 7'h03, 7'h78}};
    tv[6] = '{16'h9D26, 1'b0, 4'hF, 4'hF, {7'h10, 7'h21, 7'h24, 7'h02}};
    tv[7] = '{16'h0C05, 1'b1, 4'hF, 4'h7, {7'h7F, 7'h46, 7'h40, 7'h12}};

    bus.value = '0; bus.load = 1'b0; bus.digit_en = 4'hF;
    bus.blink_mask = 4'h0; bus.lzs_en = 1'b0; bus.dp_in = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {bus.frame_done, bus.dp, bus.an, bus.seg7}, {1'b0, 1'b1, 4'hF, 7'h7F});
    rst_n = 1'b1;

    // Frame coherence: pending load mid-frame, bypass load on the wrap edge
    goto(6);
    do_load(16'h1234, e);
    goto(14);
    check("coh_old_d3", {bus.an, bus.seg7}, {4'b0111, 7'h40});
    goto(15);
    check("coh_fd_low", bus.frame_done, 1'b0);
    bus.value = 16'h5678;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    check("coh_fd_wrap", {bus.frame_done, bus.an}, {1'b1, 4'hF});
    goto(18); check("coh_new_d0", {bus.an, bus.seg7}, {4'b1110, 7'h00});
    goto(22); check("coh_new_d1", {bus.an, bus.seg7}, {4'b1101, 7'h78});
    goto(30); check("coh_new_d3", {bus.an, bus.seg7}, {4'b0111, 7'h12});

    // Blink on digit 0: frames 0,1 on, 2,3 off, 4,5 on, 6 off
    bus.blink_mask = 4'b0001;
    goto(34); check("blink_f2_d0", {bus.an, bus.seg7}, {4'hF, 7'h7F});
    goto(38); check("blink_f2_d1", {bus.an, bus.seg7}, {4'b1101, 7'h78});
    goto(50); check("blink_f3_d0", {bus.an, bus.seg7}, {4'hF, 7'h7F});
    goto(66); check("blink_f4_d0", {bus.an, bus.seg7}, {4'b1110, 7'h00});
    goto(82); check("blink_f5_d0", {bus.an, bus.seg7}, {4'b1110, 7'h00});
    goto(98); check("blink_f6_d0", {bus.an, bus.seg7}, {4'hF, 7'h7F});
    bus.blink_mask = 4'h0;

    for (int i = 0; i < 8; i++) begin
      bus.lzs_en   = tv[i].lzs;
      bus.digit_en = tv[i].en;
      bus.dp_in    = 4'b0101;
      do_load(tv[i].val, e);
      f = (e + RN - 1) / RN;
      for (int d = 0; d < 4; d++) begin
        goto(f * RN + d * R + 2);
        exp_an = tv[i].lit[d] ? ~(4'b0001 << d) : 4'hF;
        check($sformatf("vec%0d_d%0d", i, d), {bus.an, bus.seg7}, {exp_an, tv[i].seg[d]});
      end
    end

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        for (int n = 0; n < 4; n++)
          bus.value[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) bus.digit_en   = 4'($urandom) | 4'b0001;
      if ($urandom_range(0, 15) == 0) bus.blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.lzs_en     = 1'($urandom);
      if ($urandom_range(0, 7) == 0)  bus.dp_in      = 4'($urandom);
    end
    @(negedge clk);
    bus.load = 1'b0; bus.digit_en = 4'hF; bus.blink_mask = 4'h0;
    bus.lzs_en = 1'b0; bus.dp_in = 4'h0;

    // Asynchronous reset in the middle of digit 2's slot
    f = k / RN + 1;
    goto(f * RN + 2 * R + 2);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {bus.dp, bus.an, bus.seg7}, {1'b1, 4'hF, 7'h7F});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(2);  check("post_rst_d0", {bus.an, bus.seg7}, {4'b1110, 7'h40});
    goto(14); check("post_rst_d3", {bus.an, bus.seg7}, {4'b0111, 7'h40});

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multi-digit, time-multiplexed seven-segment display driver. It latches a packed hex value, decodes one nibble per scan slot, and drives a shared active-low segment bus plus active-low digit anodes. It also provides per-digit enable, blinking, leading-zero suppression and frame-coherent updates. It sits between datapath registers and the board display pins and replaces per-digit static decoders when digits share segment lines.

## Interface
- `NUM_DIGITS`, default 4: digits scanned, legal range 1..8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot, minimum 2.
- `BLINK_FRAMES`, default 64: full frames per blink half-period, minimum 1.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 4*NUM_DIGITS: packed hex digits; digit 0 is bits [3:0] and is the rightmost digit.
- `load` in 1: one-cycle strobe that captures `value` into the pending register.
- `digit_en` in NUM_DIGITS: per-digit enable; 0 blanks that digit.
- `blink_mask` in NUM_DIGITS: 1 makes that digit blink.
- `lzs_en` in 1: leading-zero suppression enable.
- `dp_in` in NUM_DIGITS: per-digit decimal point, active-high request.
- `seg7` out 7: segments, bit 0 = a … bit 6 = g; 0 = ON.
- `dp` out 1: decimal point; 0 = ON.
- `an` out NUM_DIGITS: digit anodes; 0 = selected.
- `frame_done` out 1: one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

## Operation
- **Prescaler.** Counts 0..REFRESH_DIV-1. A `tick` fires at the terminal count. Width is $clog2(REFRESH_DIV).
- **Scan index.** `idx` is 0..NUM_DIGITS-1 and advances on each `tick`. It wraps to 0 after NUM_DIGITS-1. `frame_done` pulses on the wrapping tick.
- **Double buffering.**
  - `load` writes the pending register.
  - On each wrapping tick, pending is copied to the shadow register, so a frame never mixes old and new values.
  - If `load` coincides with the wrapping tick, the new `value` bypasses straight into shadow.
- **Blink.**
  - A frame counter counts 0..BLINK_FRAMES-1 on `frame_done` and toggles `blink_on` at its terminal count.
  - `blink_on` resets to 1 (visible).
- **Blanking.** Digit i is blanked when any of the following holds:
  - `digit_en[i]`=0;
  - `blink_mask[i]`=1 and `blink_on`=0;
  - leading-zero suppression: `lzs_en`=1, i>0, and shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never zero-suppressed.
- **Blanked digit output.** `seg7`=7'h7F, `dp`=1, `an` all 1.
- **Decode.** Shadow nibble selected by `idx` maps to active-low glyphs 0-9, A, b, C, d, E, F. Examples: 0→1000000, 1→1111001, 5→0010010, A→0001000, F→0001110.

## Timing
- **Reset values (asynchronous):** `seg7`=7'h7F, `dp`=1, `an`=all 1, `frame_done`=0, `idx`=0, prescaler=0, pending=0, shadow=0, `blink_on`=1, frame counter=0.
- **Registered outputs.** All outputs are registered and change only on the rising edge of `clk`.
- **Dead time.** The first cycle after each `tick` drives `an` all 1 (anti-ghosting). The new digit's `an`/`seg7`/`dp` appear one cycle later and hold for the remaining REFRESH_DIV-1 cycles.
- **Refresh rates.** Frame period is NUM_DIGITS×REFRESH_DIV cycles. Blink half-period is BLINK_FRAMES frames.
- **Input sampling.** `digit_en`, `blink_mask`, `lzs_en` and `dp_in` are sampled live each cycle and take effect on the next edge.
- **First frame after reset.** Shows all zeros (only digit 0 visible if `lzs_en`=1).
- **Reset mid-slot.** Reset asserted mid-slot blanks the outputs immediately, without waiting for a clock edge. After release, scanning restarts at digit 0 with a full slot.

## Structure
- Shared package `seg7_pkg`:
  - `SEG_BLANK`=7'h7F;
  - the 16 glyph constants;
  - the active-low polarity constants `SEG_ON`/`SEG_OFF`.
- One combinational sub-module, `seg7_hex_lut` (nibble → active-low 7-bit glyph), built from the package constants.
- Prescaler, scan index, blink counter, buffers and blanking logic live in the top module.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, `digit_en`=4'hF, `blink_mask`=0, `lzs_en`=0 unless stated.
- **Reset:** release `rst_n` → `frame_done` every 16 cycles; `an` sequence 1110, 1101, 1011, 0111, each slot preceded by one cycle of 1111.
- **Decode:** load 16'h1A3F → next frame `seg7` per slot = 0001110, 0110000, 0001000, 1111001 (F, 3, A, 1).
- **Leading-zero suppression:** `lzs_en`=1, load 16'h0050 → digits 3 and 2 blank (`an` 1111), digit 1 = 0010010, digit 0 = 1000000. Load 16'h0000 → only digit 0 lit, showing 1000000.
- **Blink:** `blink_mask`=4'b0001 → digit 0 visible for 2 frames, blank for 2 frames, repeating; digits 1-3 unaffected.
- **Frame coherence:** load 16'h1234 during slot 1, then 16'h5678 coincident with the wrapping tick → the current frame keeps old digits and the next frame shows 5678.
- **Reset mid-operation:** assert `rst_n`=0 mid-slot 2 → `seg7`=7F, `an`=F, `dp`=1 without waiting for an edge; after release, display shows 0000.
